// File: rtl/ship_pkg.sv
// Shared ship-wide definitions: mode codes, ammo-loader state encoding and defaults.
// Also used by the weapons block for ATTACK_MODE.
package ship_pkg;

    localparam logic [3:0]  ATTACK_MODE      = 4'b0010;
    localparam int unsigned MAX_AMMO_DEFAULT = 300;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    function automatic int unsigned max_uint(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stock_counter.sv
// Saturating stockpile counter: debit and credit land in the same cycle, and the
// result clamps at the all-ones value. The debit never exceeds the current count.
module stock_counter #(
    parameter int unsigned SW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] i_add,
    input  logic [SW-1:0] i_sub,
    output logic [SW-1:0] o_stock,
    output logic [SW-1:0] o_stock_nxt
);

    logic [SW-1:0] r_stock;
    logic [SW:0]   w_sum;

    // One guard bit holds any carry from (stock - sub) + add; clamp on carry.
    assign w_sum       = ({1'b0, r_stock} - {1'b0, i_sub}) + {1'b0, i_add};
    assign o_stock_nxt = w_sum[SW] ? {SW{1'b1}} : w_sum[SW-1:0];
    assign o_stock     = r_stock;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stock <= '0;
        end else begin
            r_stock <= o_stock_nxt;
        end
    end

endmodule

// File: rtl/ammo_loader.sv
// Supply-side ammo loader: accepts reload requests, streams rounds into the
// weapon magazine in chunks while debiting the stockpile, then pulses done.
module ammo_loader
    import ship_pkg::*;
#(
    parameter int unsigned N        = 9,
    parameter int unsigned MAX_AMMO = MAX_AMMO_DEFAULT,
    parameter int unsigned CHUNK    = 16,
    parameter int unsigned SW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    mode,
    input  logic          reload_req,
    input  logic [N-1:0]  cur_ammo,
    input  logic          restock_valid,
    input  logic [SW-1:0] restock_amt,
    output logic [N-1:0]  ammo_out,
    output logic          loading,
    output logic          reload_done,
    output logic [SW-1:0] stock,
    output logic          error
);

    localparam int unsigned WW = max_uint(N, SW);

    loader_state_t r_state, w_state_nxt;
    logic [N-1:0]  r_ammo, w_ammo_nxt;
    logic          r_loading, w_loading_nxt;
    logic          r_done, w_done_nxt;
    logic          r_error, w_error_nxt;

    logic          w_attack;
    logic [WW-1:0] w_room;
    logic [WW-1:0] w_stock_wide;
    logic [WW-1:0] w_step;
    logic [SW-1:0] w_sub;
    logic [SW-1:0] w_add;
    logic [SW-1:0] w_stock_nxt;

    assign w_attack     = (mode == ATTACK_MODE);
    assign w_room       = WW'(MAX_AMMO) - WW'(r_ammo);
    assign w_stock_wide = WW'(stock);

    // step = min(CHUNK, room left in the magazine, stockpile)
    always_comb begin
        w_step = WW'(CHUNK);
        if (w_room < w_step)       w_step = w_room;
        if (w_stock_wide < w_step) w_step = w_stock_wide;
    end

    assign w_sub = (r_state == ST_XFER) ? w_step[SW-1:0] : '0;
    assign w_add = restock_valid ? restock_amt : '0;

    stock_counter #(.SW(SW)) u_stock (
        .clk        (clk),
        .rst_n      (rst),
        .i_add      (w_add),
        .i_sub      (w_sub),
        .o_stock    (stock),
        .o_stock_nxt(w_stock_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_ammo_nxt  = r_ammo;
        w_done_nxt  = 1'b0;
        w_error_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (reload_req) begin
                    if (w_attack || (stock == '0)) begin
                        w_error_nxt = 1'b1;
                    end else if (cur_ammo >= N'(MAX_AMMO)) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_ammo_nxt  = cur_ammo;
                        w_state_nxt = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                w_state_nxt = w_attack ? ST_DONE : ST_XFER;
            end
            ST_XFER: begin
                // An abort still lets this cycle's step land; it only ends the transfer.
                w_ammo_nxt = r_ammo + w_step[N-1:0];
                if (w_attack || (w_ammo_nxt == N'(MAX_AMMO)) || (w_stock_nxt == '0)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_state_nxt == ST_DONE) begin
            w_done_nxt = 1'b1;
        end
        w_loading_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ammo    <= '0;
            r_loading <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_ammo    <= w_ammo_nxt;
            r_loading <= w_loading_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
        end
    end

    assign ammo_out    = r_ammo;
    assign loading     = r_loading;
    assign reload_done = r_done;
    assign error       = r_error;

endmodule

// File: tb/tb_ammo_loader.sv
// Self-checking bench for ammo_loader: directed scenarios plus randomized traffic,
// all scored against a cycle-level reference model of the loader's rules.
module tb_ammo_loader;

    localparam int N        = 9;
    localparam int MAX_AMMO = 300;
    localparam int CHUNK    = 16;
    localparam int SW       = 12;
    localparam int STOCK_MAX = (1 << SW) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_LATCH = 1;
    localparam int P_XFER  = 2;
    localparam int P_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    mode;
    logic          reload_req;
    logic [N-1:0]  cur_ammo;
    logic          restock_valid;
    logic [SW-1:0] restock_amt;
    logic [N-1:0]  ammo_out;
    logic          loading;
    logic          reload_done;
    logic [SW-1:0] stock;
    logic          error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model state
    int m_phase, m_ammo, m_stock;
    bit m_loading, m_done, m_err;

    ammo_loader #(.N(N), .MAX_AMMO(MAX_AMMO), .CHUNK(CHUNK), .SW(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .reload_req   (reload_req),
        .cur_ammo     (cur_ammo),
        .restock_valid(restock_valid),
        .restock_amt  (restock_amt),
        .ammo_out     (ammo_out),
        .loading      (loading),
        .reload_done  (reload_done),
        .stock        (stock),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = P_IDLE; m_ammo = 0; m_stock = 0;
        m_loading = 0; m_done = 0; m_err = 0;
    endtask

    // Advances the model by one clock using the inputs present at the edge.
    task automatic model_clock();
        int  step, add, nstock;
        bit  attack;
        attack = (mode == 4'b0010);
        add    = restock_valid ? int'(restock_amt) : 0;
        step   = 0;
        if (m_phase == P_XFER) begin
            step = CHUNK;
            if (MAX_AMMO - m_ammo < step) step = MAX_AMMO - m_ammo;
            if (m_stock < step)           step = m_stock;
        end
        nstock = m_stock - step + add;
        if (nstock > STOCK_MAX) nstock = STOCK_MAX;
        m_done = 0;
        m_err  = 0;
        case (m_phase)
            P_IDLE: begin
                if (reload_req) begin
                    if (attack || m_stock == 0)         m_err = 1;
                    else if (int'(cur_ammo) >= MAX_AMMO) m_done = 1;
                    else begin
                        m_ammo  = int'(cur_ammo);
                        m_phase = P_LATCH;
                    end
                end
            end
            P_LATCH: m_phase = attack ? P_DONE : P_XFER;
            P_XFER: begin
                m_ammo = m_ammo + step;
                if (attack || m_ammo == MAX_AMMO || nstock == 0) m_phase = P_DONE;
            end
            default: m_phase = P_IDLE;
        endcase
        m_stock   = nstock;
        m_loading = (m_phase != P_IDLE);
        if (m_phase == P_DONE) m_done = 1;
    endtask

    // One clock: advance model, then compare every output against it.
    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        cyc++;
        checks++;
        if (ammo_out !== N'(m_ammo)) begin
            errors++; $display("FAIL model_ammo_out cyc=%0d got=%0d exp=%0d", cyc, ammo_out, m_ammo);
        end
        checks++;
        if (stock !== SW'(m_stock)) begin
            errors++; $display("FAIL model_stock cyc=%0d got=%0d exp=%0d", cyc, stock, m_stock);
        end
        checks++;
        if (loading !== m_loading) begin
            errors++; $display("FAIL model_loading cyc=%0d got=%b exp=%b", cyc, loading, m_loading);
        end
        checks++;
        if (reload_done !== m_done) begin
            errors++; $display("FAIL model_reload_done cyc=%0d got=%b exp=%b", cyc, reload_done, m_done);
        end
        checks++;
        if (error !== m_err) begin
            errors++; $display("FAIL model_error cyc=%0d got=%b exp=%b", cyc, error, m_err);
        end
    endtask

    task automatic idle_inputs();
        mode = 4'b0001; reload_req = 0; cur_ammo = '0;
        restock_valid = 0; restock_amt = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic restock(input int amt);
        restock_valid = 1; restock_amt = SW'(amt);
        tick();
        restock_valid = 0; restock_amt = '0;
    endtask

    task automatic request(input int a);
        cur_ammo = N'(a); reload_req = 1;
        tick();
        reload_req = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ammo_out, loading, reload_done, stock, error} !== '0) begin
            errors++; $display("FAIL reset_state got ammo=%0d ld=%b dn=%b st=%0d er=%b exp all 0",
                               ammo_out, loading, reload_done, stock, error);
        end
        restock(100);
        request(0);
        tick(); tick(); tick();   // mid-XFER
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({ammo_out, loading, reload_done, stock, error} !== '0) begin
            errors++; $display("FAIL reset_mid_xfer got ammo=%0d ld=%b dn=%b st=%0d er=%b exp all 0",
                               ammo_out, loading, reload_done, stock, error);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (reload_done !== 1'b0) begin
                errors++; $display("FAIL reset_no_done cyc=%0d got=%b exp=0", cyc, reload_done);
            end
        end
    endtask

    task automatic test_full_reload();
        int exp_ammo[4]  = '{266, 282, 298, 300};
        int exp_stock[4] = '{84, 68, 52, 50};
        do_reset();
        restock(100);
        request(250);
        checks++;
        if (ammo_out !== 9'd250 || loading !== 1'b1) begin
            errors++; $display("FAIL full_latch got ammo=%0d ld=%b exp 250/1", ammo_out, loading);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ammo_out !== N'(exp_ammo[i]) || stock !== SW'(exp_stock[i])) begin
                errors++; $display("FAIL full_xfer%0d got ammo=%0d stock=%0d exp %0d/%0d",
                                   i, ammo_out, stock, exp_ammo[i], exp_stock[i]);
            end
        end
        checks++;
        if (reload_done !== 1'b1 || loading !== 1'b1) begin
            errors++; $display("FAIL full_done got dn=%b ld=%b exp 1/1", reload_done, loading);
        end
        tick();
        checks++;
        if (loading !== 1'b0 || ammo_out !== 9'd300 || reload_done !== 1'b0) begin
            errors++; $display("FAIL full_idle got ld=%b ammo=%0d dn=%b exp 0/300/0", loading, ammo_out, reload_done);
        end
    endtask

    task automatic test_stock_limited();
        do_reset();
        restock(20);
        request(0);
        tick();
        tick();
        checks++;
        if (ammo_out !== 9'd16 || stock !== 12'd4) begin
            errors++; $display("FAIL limited_step1 got ammo=%0d stock=%0d exp 16/4", ammo_out, stock);
        end
        tick();
        checks++;
        if (ammo_out !== 9'd20 || stock !== 12'd0 || reload_done !== 1'b1) begin
            errors++; $display("FAIL limited_step2 got ammo=%0d stock=%0d dn=%b exp 20/0/1", ammo_out, stock, reload_done);
        end
        tick(); tick();
        checks++;
        if (ammo_out !== 9'd20 || loading !== 1'b0) begin
            errors++; $display("FAIL limited_hold got ammo=%0d ld=%b exp 20/0", ammo_out, loading);
        end
    endtask

    task automatic test_rejections();
        do_reset();
        restock(50);
        mode = 4'b0010;
        request(10);
        checks++;
        if (error !== 1'b1 || loading !== 1'b0 || reload_done !== 1'b0) begin
            errors++; $display("FAIL reject_attack got er=%b ld=%b dn=%b exp 1/0/0", error, loading, reload_done);
        end
        tick();
        checks++;
        if (error !== 1'b0 || loading !== 1'b0) begin
            errors++; $display("FAIL reject_attack_pulse got er=%b ld=%b exp 0/0", error, loading);
        end
        do_reset();
        request(10);
        checks++;
        if (error !== 1'b1 || loading !== 1'b0) begin
            errors++; $display("FAIL reject_empty got er=%b ld=%b exp 1/0", error, loading);
        end
        restock(10);
        request(300);
        checks++;
        if (reload_done !== 1'b1 || error !== 1'b0 || loading !== 1'b0 || stock !== 12'd10) begin
            errors++; $display("FAIL already_full got dn=%b er=%b ld=%b st=%0d exp 1/0/0/10",
                               reload_done, error, loading, stock);
        end
        tick();
    endtask

    task automatic test_abort_restock();
        do_reset();
        restock(200);
        request(0);
        tick(); tick(); tick();
        checks++;
        if (ammo_out !== 9'd32) begin
            errors++; $display("FAIL abort_pre got ammo=%0d exp 32", ammo_out);
        end
        mode = 4'b0010; restock_valid = 1; restock_amt = 12'd4095;
        tick();
        mode = 4'b0001; restock_valid = 0; restock_amt = '0;
        checks++;
        if (ammo_out !== 9'd48 || stock !== 12'd4095 || reload_done !== 1'b1 || loading !== 1'b1) begin
            errors++; $display("FAIL abort_done got ammo=%0d st=%0d dn=%b ld=%b exp 48/4095/1/1",
                               ammo_out, stock, reload_done, loading);
        end
        tick();
        checks++;
        if (ammo_out !== 9'd48 || loading !== 1'b0) begin
            errors++; $display("FAIL abort_idle got ammo=%0d ld=%b exp 48/0", ammo_out, loading);
        end
    endtask

    task automatic test_ignore_midxfer();
        int dones;
        dones = 0;
        do_reset();
        restock(100);
        request(200);
        for (int i = 0; i < 14; i++) begin
            reload_req = (i >= 1 && i < 4);
            cur_ammo   = '0;
            tick();
            if (reload_done === 1'b1) dones++;
        end
        reload_req = 0;
        checks++;
        if (dones != 1 || ammo_out !== 9'd300 || stock !== 12'd0) begin
            errors++; $display("FAIL ignore_req got dones=%0d ammo=%0d st=%0d exp 1/300/0", dones, ammo_out, stock);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            mode          = ($urandom_range(0, 5) == 0) ? 4'b0010 : 4'($urandom_range(0, 15));
            reload_req    = ($urandom_range(0, 2) == 0);
            cur_ammo      = N'($urandom_range(0, 320));
            restock_valid = ($urandom_range(0, 3) == 0);
            restock_amt   = ($urandom_range(0, 20) == 0) ? 12'd4095 : SW'($urandom_range(0, 60));
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        test_reset();
        test_full_reload();
        test_stock_limited();
        test_rejections();
        test_abort_restock();
        test_ignore_midxfer();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ammo_loader.md
Name: ammo_loader

Overview:
- Supply-side responder for the weapons block's ammo-load interface.
- Holds the ship's ammunition stockpile.
- Accepts reload requests carrying the weapon's current ammo count.
- Drives `ammo_out`/`loading` in chunked transfers up to magazine capacity, debiting the stockpile, then signals completion.
- Sits between the cargo/restock path and the weapons block: `ammo_out` feeds weapons `ammo`; `loading` feeds weapons `loadingAmmo`.

Parameters:
- N, 9, magazine count width (matches weapons ammo width)
- MAX_AMMO, 300, magazine capacity; must be < 2^N
- CHUNK, 16, max rounds transferred per cycle
- SW, 12, stockpile counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  4  ship mode; 4'b0010 = attack
- reload_req  in  1  request reload; sampled only in IDLE
- cur_ammo  in  N  weapon's current ammo (weapons newAmmo)
- restock_valid  in  1  add restock_amt to stockpile this cycle
- restock_amt  in  SW  rounds delivered from cargo
- ammo_out  out  N  running magazine value presented to weapons
- loading  out  1  high while a transfer is in progress (weapons loadingAmmo)
- reload_done  out  1  one-cycle pulse at end of reload (full, partial, or abort)
- stock  out  SW  current stockpile
- error  out  1  one-cycle pulse on rejected request

Behaviour:
- Reset (rst=0, async): state=IDLE; stock=0; ammo_out=0; loading=0; reload_done=0; error=0. Reset during a transfer abandons it; no done pulse.
- States: IDLE, LATCH, XFER, DONE. All outputs are registered.
- IDLE, on reload_req=1:
  - mode==4'b0010: error=1 next cycle, stay IDLE (no reload in attack mode).
  - else stock==0: error=1 next cycle, stay IDLE.
  - else cur_ammo>=MAX_AMMO: reload_done=1 next cycle, no transfer, stay IDLE.
  - else: ammo_out<=cur_ammo, go to LATCH.
- LATCH: one cycle; loading=1; go to XFER.
- XFER, each cycle:
  - step = min(CHUNK, MAX_AMMO-ammo_out, stock).
  - ammo_out += step; stock -= step; loading=1.
  - If the post-update ammo_out==MAX_AMMO or post-update stock==0, go to DONE.
- Abort: mode==4'b0010 during LATCH or XFER → go to DONE next cycle with no further step. The partial load is retained; rounds already debited are not returned.
- DONE: loading=1 for this final cycle so weapons latch the final ammo_out; reload_done=1; then IDLE with loading=0.
- Latency: full reload from cur_ammo=a takes 1 (LATCH) + ceil((MAX_AMMO-a)/CHUNK) (XFER) + 1 (DONE) cycles when stock suffices.
- reload_req outside IDLE is ignored (not queued).
- Restock, any state:
  - next stock = sat(stock - step + restock_amt) at 2^SW-1.
  - Saturation applies after the same-cycle debit; stock never underflows because step ≤ stock.
- ammo_out holds its last value in IDLE; it changes only in IDLE-accept, XFER, or reset.
- error and reload_done are never both high in the same cycle.
- Arithmetic:
  - step is computed at max(N,SW) width, then truncated to N.
  - MAX_AMMO-ammo_out is never negative in XFER.

Decomposition:
- Shared package (ship_pkg):
  - ATTACK_MODE = 4'b0010 (also used by weapons).
  - Loader state encoding.
  - MAX_AMMO default.
- Sub-module stock_counter: SW-bit saturating up/down counter.
  - Inputs: add amount, sub amount.
  - Async active-low reset.
  - Output: stock.
- The FSM and step computation live in ammo_loader.

Test Plan:
- Reset: hold rst=0 mid-XFER → all outputs 0 immediately; release → IDLE, no reload_done pulse.
- Full reload: restock 100, mode=4'b0001, cur_ammo=250, reload_req pulse → ammo_out 250 (LATCH), then 266, 282, 298, 300 in XFER; stock 84, 68, 52, 50; DONE: reload_done=1, loading=1; then loading=0, ammo_out=300.
- Stock-limited: stock=20, cur_ammo=0 → ammo_out 16, 20; stock 4, 0; reload_done pulse; ammo_out stays 20.
- Rejections:
  - mode=4'b0010 with reload_req → error 1 cycle, loading stays 0.
  - stock=0 in mode 0001 → error 1 cycle.
  - cur_ammo=300 → reload_done only, stock unchanged.
- Abort plus restock: stock=200, cur_ammo=0; after 2 XFER cycles (ammo_out=32), set mode=4'b0010 with restock_valid=1, restock_amt=4095 in the same cycle → next XFER step (16) still applies that cycle, then DONE; ammo_out=48; stock saturates at 4095.
- Request ignored mid-transfer: reload_req re-asserted during XFER has no effect; exactly one reload_done per accepted request.
